// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Raises busy while computing so the hazard unit can stall F/D/E; accepts FlushE.
module div_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} stateT;

  stateT           state;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] remQ;
  logic [XLEN-1:0] quoQ;
  logic [XLEN-1:0] divQ;
  logic            isRem;
  logic            negQ;
  logic            negR;

  // Operand decode, used only on the accepting edge in IDLE.
  logic            isSigned;
  logic            aNeg;
  logic            bNeg;
  logic [XLEN-1:0] magA;
  logic [XLEN-1:0] magB;
  logic            bZero;
  logic            sOvf;
  logic [XLEN-1:0] specialRes;

  assign isSigned   = ~funct3[0];
  assign aNeg       = isSigned & a[XLEN-1];
  assign bNeg       = isSigned & b[XLEN-1];
  assign magA       = aNeg ? -a : a;
  assign magB       = bNeg ? -b : b;
  assign bZero      = (b == '0);
  assign sOvf       = isSigned & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign specialRes = bZero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

  // One restoring step: quoQ doubles as the dividend shift register.
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;
  logic [XLEN-1:0] nextRem;
  logic [XLEN-1:0] nextQuo;
  logic [XLEN-1:0] finalRes;

  assign shifted  = {remQ, quoQ[XLEN-1]};
  assign diff     = {1'b0, shifted} - {2'b00, divQ};
  assign borrow   = diff[XLEN+1];
  assign nextRem  = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign nextQuo  = {quoQ[XLEN-2:0], ~borrow};
  assign finalRes = isRem ? (negR ? -nextRem : nextRem) : (negQ ? -nextQuo : nextQuo);

  assign busy = ((state == StIdle) & start & ~flush) | (state == StCalc);
  assign done = (state == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      cnt    <= '0;
      result <= '0;
      remQ   <= '0;
      quoQ   <= '0;
      divQ   <= '0;
      isRem  <= 1'b0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
    end else if (flush) begin
      state <= StIdle;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            isRem <= funct3[1];
            negQ  <= aNeg ^ bNeg;
            negR  <= aNeg;
            divQ  <= magB;
            quoQ  <= magA;
            remQ  <= '0;
            if (bZero || sOvf) begin
              result <= specialRes;
              state  <= StDone;
            end else begin
              cnt   <= CNTW'(XLEN);
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          remQ <= nextRem;
          quoQ <= nextQuo;
          cnt  <= cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            result <= finalRes;
            state  <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the Execute stage and is the requesting end of the pipeline stall interface: it raises a stall request (busy) for the hazard unit, and it accepts the hazard unit's Execute flush.
- While busy is high, the hazard unit holds the F, D and E stages and inserts a bubble into M.

Parameters:
- XLEN, 32, operand/result width in bits (must be ≥ 2).
- CNTW, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  divide instruction valid in E (from decode control)
- funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  dividend (post-forwarding SrcAE)
- b  input  XLEN  divisor (post-forwarding SrcBE)
- flush  input  1  FlushE from hazard unit
- busy  output  1  stall request to hazard unit (combinational)
- done  output  1  result valid, one-cycle pulse
- result  output  XLEN  quotient or remainder, stable while done=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0, result=0.
  - done=0; busy=0 (combinational from state and inputs).
- States and transitions:
  - IDLE:
    - start=1, flush=0 → latch funct3, operand magnitudes and sign flags.
    - b==0 or signed overflow → DONE.
    - Otherwise → CALC with counter=XLEN.
  - CALC:
    - Each cycle performs one restoring step: shift the remainder left, bring in the dividend MSB, then trial-subtract the divisor magnitude. Quotient bit = no borrow.
    - Counter decrements each step.
    - Counter==1 on this edge → DONE.
  - DONE:
    - done=1 and result driven; start is ignored.
    - → IDLE next cycle unconditionally.
- busy = (IDLE & start & ~flush) | CALC.
  - busy is low in DONE, so the pipeline advances on the DONE edge.
- Latency:
  - Normal case: start sampled at cycle T; busy high T..T+XLEN; done at T+XLEN+1.
  - Special case: busy high at T only; done at T+1.
- Signed ops (DIV/REM):
  - Operate on magnitudes.
  - Quotient negated if sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - Unsigned ops bypass all sign handling.
- Special cases (RISC-V defined, no trap):
  - b==0: quotient = all ones, remainder = a (all four ops).
  - DIV/REM with a=100…0 and b=all ones: quotient = a, remainder = 0.
- flush:
  - flush=1 in any state → IDLE next edge, result unchanged.
  - done is not asserted for the flushed operation.
  - flush has priority over start and over CALC completion.
- Back-to-back:
  - A new start is accepted only in IDLE, i.e. at the earliest the cycle after DONE.
- result:
  - Registered at DONE entry.
  - Held until the next DONE entry or reset.
- Reset mid-CALC: aborts immediately; all outputs return to reset values.

Test Plan:
- Reset during CALC (counter=10), reset asserted asynchronously mid-cycle → busy, done and result go to 0 immediately; state=IDLE after release.
- DIVU a=100, b=7, start held at T → busy=1 for cycles T..T+32; done=1 at T+33 with result=14; REMU with the same operands gives result=2.
- DIV a=-7 (0xFFFFFFF9), b=2 → result=0xFFFFFFFD (-3); REM with the same operands → 0xFFFFFFFF (-1); REM a=7, b=-2 → 1.
- Divide by zero: DIV a=5, b=0 → done at T+1, result=0xFFFFFFFF, busy high only at T; REMU a=5, b=0 → result=5.
- Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF → result=0x80000000 at T+1; REM with the same operands → 0.
- flush asserted at T+5 of a DIVU → busy=0 from T+6, no done pulse, previous result retained; a new DIVU 9/3 at T+7 → done at T+40, result=3.
